// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes, FSM states, latched fields.
// Pure declarations (no latency, no backpressure).
package multicycle_controller_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_NOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } fields_t;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    return is_alu_op(op) || is_mem_op(op);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_cc_decoder.sv
// Combinational (opcode, funct3, funct7) -> ALU operation code, first matching row wins.
// Zero latency, no backpressure; unsupported opcodes decode to 0000.
module alu_cc_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_cc_o
);

  always_comb begin
    alu_cc_o = ALU_AND;
    if (is_alu_op(opcode_i)) begin
      if ((funct7_i == F7_ZERO) && (funct3_i == F3_ADD)) begin
        alu_cc_o = ALU_ADD;
      end else if (funct7_i == F7_ALT) begin
        alu_cc_o = ALU_SUB;
      end else if (funct3_i == F3_NOR) begin
        alu_cc_o = ALU_NOR;
      end else if (funct3_i == F3_OR) begin
        alu_cc_o = ALU_OR;
      end else if (funct3_i == F3_AND) begin
        alu_cc_o = ALU_AND;
      end else if (funct3_i == F3_SLT) begin
        alu_cc_o = ALU_SLT;
      end
    end else if (is_mem_op(opcode_i) && (funct3_i == F3_W)) begin
      // word loads/stores compute their address with an add
      alu_cc_o = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequenced FETCH/DECODE/EXEC/MEM/WB control unit; R/I 4 cycles, LW 5, SW 4 plus MEM waits.
// Stalls in FETCH until instr_valid and in MEM until mem_ready or MEM_TIMEOUT cycles elapse.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             instr_valid,
  input  logic             mem_ready,
  output logic             fetch_req,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       alu_cc,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  fields_t           fields_q, fields_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mem_err_q, mem_err_d;
  logic [3:0]        dec_cc;
  logic              is_lw, is_sw, uses_imm, active;

  alu_cc_decoder u_alu_cc_decoder (
    .opcode_i (fields_q.opcode),
    .funct3_i (fields_q.funct3),
    .funct7_i (fields_q.funct7),
    .alu_cc_o (dec_cc)
  );

  assign is_lw    = (fields_q.opcode == OP_LW);
  assign is_sw    = (fields_q.opcode == OP_SW);
  assign uses_imm = (fields_q.opcode == OP_I) || is_lw || is_sw;
  assign active   = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM)    || (state_q == ST_WB);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      fields_q  <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fields_d  = fields_q;
    wait_d    = '0;
    count_d   = count_q;
    mem_err_d = 1'b0;
    fetch_req = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          fields_d.opcode = opcode;
          fields_d.funct3 = funct3;
          fields_d.funct7 = funct7;
          state_d         = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_supported(fields_q.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: state_d = is_mem_op(fields_q.opcode) ? ST_MEM : ST_WB;
      ST_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        // ready takes precedence over a timeout landing on the same cycle
        if (mem_ready) begin
          if (is_lw) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            count_d = count_q + CNT_W'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        mem2reg   = is_lw;
        state_d   = ST_FETCH;
        count_d   = count_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Held at zero outside an instruction so IDLE/FETCH never leak stale controls.
  assign alu_src     = active && uses_imm;
  assign alu_cc      = active ? dec_cc : 4'b0000;
  assign mem_err     = mem_err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, corner sequences, random run.
module tb_multicycle_controller;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       instr_valid = 1'b0;
  logic       mem_ready = 1'b0;

  logic        fetch_req, reg_write, mem2reg, alu_src, mem_read, mem_write, illegal, mem_err;
  logic [3:0]  alu_cc;
  logic [31:0] instr_count;

  logic        fetch_req_n, reg_write_n, mem2reg_n, alu_src_n, mem_read_n, mem_write_n;
  logic        illegal_n, mem_err_n;
  logic [3:0]  alu_cc_n;
  logic [3:0]  instr_count_n;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .fetch_req(fetch_req),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .alu_cc(alu_cc), .illegal(illegal), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .fetch_req(fetch_req_n),
    .reg_write(reg_write_n), .mem2reg(mem2reg_n), .alu_src(alu_src_n), .mem_read(mem_read_n),
    .mem_write(mem_write_n), .alu_cc(alu_cc_n), .illegal(illegal_n), .mem_err(mem_err_n),
    .instr_count(instr_count_n)
  );

  // d = MEM cycle (1-based) on which mem_ready is raised, 0 = never
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int d, cc, src, cyc, rw, m2r, rd, wr, ill, err, inc;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input int d);
    vec_t v;
    bit rt, lw, sw, served;
    int waits;
    v  = '{op, f3, f7, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rt = (op == 7'b0110011) || (op == 7'b0010011);
    lw = (op == 7'b0000011);
    sw = (op == 7'b0100011);
    if (rt) begin
      if (f7 == 7'd0 && f3 == 3'd0) v.cc = 2;
      else if (f7 == 7'b0100000) v.cc = 6;
      else if (f3 == 3'b100) v.cc = 12;
      else if (f3 == 3'b110) v.cc = 1;
      else if (f3 == 3'b111) v.cc = 0;
      else if (f3 == 3'b010) v.cc = 7;
    end else if ((lw || sw) && f3 == 3'b010) begin
      v.cc = 2;
    end
    v.src = int'(op == 7'b0010011 || lw || sw);
    if (!(rt || lw || sw)) begin
      v.cyc = 2; v.ill = 1;
    end else if (rt) begin
      v.cyc = 4; v.rw = 1; v.inc = 1;
    end else begin
      served = (d >= 1) && (d <= T);
      waits  = served ? d : T;
      v.rd   = lw ? waits : 0;
      v.wr   = sw ? waits : 0;
      if (!served) begin
        v.cyc = 3 + T; v.err = 1;
      end else if (lw) begin
        v.cyc = 4 + d; v.rw = 1; v.m2r = 1; v.inc = 1;
      end else begin
        v.cyc = 3 + d; v.inc = 1;
      end
    end
    return v;
  endfunction

  // Entered at a sample point with the DUT in FETCH; leaves it back in FETCH.
  task automatic run_instr(input vec_t v, input string tag);
    int cyc, rw, m2r, rd, wr, ill, err, mc, unstable, first_cc, first_src;
    bit done, seen;
    cyc = 0; rw = 0; m2r = 0; rd = 0; wr = 0; ill = 0; err = 0; mc = 0; unstable = 0;
    first_cc = -1; first_src = -1; done = 0; seen = 0;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; instr_valid = 1'b1; mem_ready = 1'b0;
    while (!done && cyc < 64) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      cyc++;
      rw += int'(reg_write); m2r += int'(mem2reg); rd += int'(mem_read);
      wr += int'(mem_write); ill += int'(illegal); err += int'(mem_err);
      if (fetch_req) begin
        done = 1;
      end else if (!seen) begin
        first_cc = int'(alu_cc); first_src = int'(alu_src); seen = 1;
      end else if (int'(alu_cc) != first_cc || int'(alu_src) != first_src) begin
        unstable++;
      end
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        mc++;
        mem_ready = (v.d != 0) && (mc == v.d);
      end
    end
    mem_ready = 1'b0;
    exp_count += v.inc;
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " cycles"}, cyc, v.cyc);
    chk({tag, " alu_cc"}, first_cc, v.cc);
    chk({tag, " alu_src"}, first_src, v.src);
    chk({tag, " ctrl_stable"}, unstable, 0);
    chk({tag, " reg_write"}, rw, v.rw);
    chk({tag, " mem2reg"}, m2r, v.m2r);
    chk({tag, " mem_read"}, rd, v.rd);
    chk({tag, " mem_write"}, wr, v.wr);
    chk({tag, " illegal"}, ill, v.ill);
    chk({tag, " mem_err"}, err, v.err);
    chk({tag, " fetch_cc_src"}, int'({alu_cc, alu_src}), 0);
    chk({tag, " count"}, int'(instr_count), exp_count);
    chk({tag, " count4"}, int'(instr_count_n), exp_count % 16);
  endtask

  vec_t tbl[16];

  initial begin
    int n, guard, idle;
    logic [6:0] op_r, f7_r;
    vec_t v;
    logic [6:0] ops[5];

    tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, 0,  2, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, 0,  6, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[2]  = '{7'b0110011, 3'b100, 7'b0000000, 0, 12, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[3]  = '{7'b0010011, 3'b110, 7'b0000000, 0,  1, 1,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[4]  = '{7'b0110011, 3'b111, 7'b0000000, 0,  0, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[5]  = '{7'b0110011, 3'b010, 7'b0000000, 0,  7, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[6]  = '{7'b0110011, 3'b001, 7'b0000000, 0,  0, 0,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[7]  = '{7'b0010011, 3'b100, 7'b0100000, 0,  6, 1,  4, 1, 0,  0,  0, 0, 0, 1};
    tbl[8]  = '{7'b0000011, 3'b010, 7'b0000000, 3,  2, 1,  7, 1, 1,  3,  0, 0, 0, 1};
    tbl[9]  = '{7'b0000011, 3'b000, 7'b0000000, 1,  0, 1,  5, 1, 1,  1,  0, 0, 0, 1};
    tbl[10] = '{7'b0100011, 3'b010, 7'b0000000, 2,  2, 1,  5, 0, 0,  0,  2, 0, 0, 1};
    tbl[11] = '{7'b0100011, 3'b010, 7'b0000000, 0,  2, 1, 18, 0, 0,  0, 15, 0, 1, 0};
    tbl[12] = '{7'b1100011, 3'b000, 7'b0000000, 0,  0, 0,  2, 0, 0,  0,  0, 1, 0, 0};
    tbl[13] = '{7'b0000011, 3'b010, 7'b0000000, 15, 2, 1, 19, 1, 1, 15,  0, 0, 0, 1};
    tbl[14] = '{7'b0100011, 3'b001, 7'b0000000, 16, 0, 1, 18, 0, 0,  0, 15, 0, 1, 0};
    tbl[15] = '{7'b0010011, 3'b000, 7'b0000000, 0,  2, 1,  4, 1, 0,  0,  0, 0, 0, 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({fetch_req, reg_write, mem2reg, alu_src, mem_read, mem_write,
                              illegal, mem_err, alu_cc}), 0);
    chk("reset count", int'(instr_count), 0);
    chk("reset outputs4", int'({fetch_req_n, reg_write_n, mem_read_n, mem_write_n, alu_cc_n,
                               instr_count_n}), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle to fetch", int'(fetch_req), 1);

    for (int i = 0; i < 16; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // reset while a load is waiting in MEM
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0; instr_valid = 1'b1; mem_ready = 1'b0;
    n = 0; guard = 0;
    while (n < 2 && guard < 20) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      guard++;
      if (mem_read) n++;
    end
    chk("rst_mid_mem reached", n, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_count = 0;
    chk("rst_mid_mem outputs", int'({fetch_req, reg_write, mem2reg, alu_src, mem_read, mem_write,
                                    illegal, mem_err, alu_cc}), 0);
    chk("rst_mid_mem count", int'(instr_count), 0);
    chk("rst_mid_mem count4", int'(instr_count_n), 0);
    @(posedge clk); #1;
    chk("rst_held fetch_req", int'(fetch_req), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_release fetch_req", int'(fetch_req), 1);

    // 17 ADDI: the 4-bit counter wraps back to 1
    for (int i = 0; i < 17; i++) run_instr(tbl[15], $sformatf("addi%0d", i));
    chk("wrap count4", int'(instr_count_n), 1);
    chk("wrap count32", int'(instr_count), 17);

    // randomized instructions against the reference model
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0000000};
    for (int i = 0; i < 60; i++) begin
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        instr_valid = 1'b0;
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d fetch_hold", i), int'(fetch_req), 1);
      end
      op_r = ops[$urandom_range(0, 4)];
      if (op_r == 7'b0000000) op_r = 7'($urandom);
      case ($urandom_range(0, 2))
        0: f7_r = 7'b0000000;
        1: f7_r = 7'b0100000;
        default: f7_r = 7'($urandom);
      endcase
      v = model(op_r, 3'($urandom), f7_r, int'($urandom_range(0, 17)));
      run_instr(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
